// File: rtl/rtl_simd_sum_reducer.sv
// Reduces four qualified SIMD lane results to a lane-sum, accumulates N_ACC of them
// into a frame sum, and queues frame sums in a show-ahead FIFO with drop/error status.
module rtl_simd_sum_reducer #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned N_ACC = 4,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_ce,
  input  logic                     clr,
  input  logic [IN_W-1:0]          z1,
  input  logic [IN_W-1:0]          z2,
  input  logic [IN_W-1:0]          z3,
  input  logic [IN_W-1:0]          z4,
  input  logic                     z1_ap_vld,
  input  logic                     z2_ap_vld,
  input  logic                     z3_ap_vld,
  input  logic                     z4_ap_vld,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic                     lane_err,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;

  logic [IN_W-1:0]   r_z1, r_z2, r_z3, r_z4;
  logic              r_v0, r_v1, r_v2;
  logic [IN_W:0]     r_p0, r_p1;
  logic [IN_W+1:0]   r_s;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_lane_err;

  logic [ACC_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_fill;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;

  logic              w_all_vld, w_any_vld;
  logic [ACC_W-1:0]  w_sum;
  logic              w_last, w_push, w_pop, w_full, w_wr, w_drop;

  assign w_all_vld = z1_ap_vld & z2_ap_vld & z3_ap_vld & z4_ap_vld;
  assign w_any_vld = z1_ap_vld | z2_ap_vld | z3_ap_vld | z4_ap_vld;

  // Input capture, adder tree and lane-error flag all advance only with ap_ce.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_z1 <= '0; r_z2 <= '0; r_z3 <= '0; r_z4 <= '0;
      r_v0 <= 1'b0; r_v1 <= 1'b0; r_v2 <= 1'b0;
      r_p0 <= '0; r_p1 <= '0; r_s <= '0;
      r_lane_err <= 1'b0;
    end else if (clr) begin
      r_z1 <= '0; r_z2 <= '0; r_z3 <= '0; r_z4 <= '0;
      r_v0 <= 1'b0; r_v1 <= 1'b0; r_v2 <= 1'b0;
      r_p0 <= '0; r_p1 <= '0; r_s <= '0;
      r_lane_err <= 1'b0;
    end else if (ap_ce) begin
      r_v0 <= w_all_vld;
      if (w_all_vld) begin
        r_z1 <= z1; r_z2 <= z2; r_z3 <= z3; r_z4 <= z4;
      end
      if (w_any_vld && !w_all_vld) r_lane_err <= 1'b1;
      r_v1 <= r_v0;
      r_p0 <= {1'b0, r_z1} + {1'b0, r_z2};
      r_p1 <= {1'b0, r_z3} + {1'b0, r_z4};
      r_v2 <= r_v1;
      r_s  <= {1'b0, r_p0} + {1'b0, r_p1};
    end
  end

  assign w_last = (r_cnt == CNT_W'(N_ACC - 1));
  assign w_sum  = (r_cnt == '0) ? ACC_W'(r_s) : r_acc + ACC_W'(r_s);
  assign w_push = ap_ce & r_v2 & w_last;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (ap_ce && r_v2) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_pop  = out_valid & out_ready;
  assign w_full = (r_fill == (PTR_W+1)'(DEPTH));
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge ap_clk) begin
    if (w_wr && !clr) r_mem[r_wr_ptr] <= w_sum;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_fill <= '0;
      r_overflow <= 1'b0; r_drop_cnt <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_fill <= '0;
      r_overflow <= 1'b0; r_drop_cnt <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_pop)      r_fill <= r_fill + (PTR_W+1)'(1);
      else if (!w_wr && w_pop) r_fill <= r_fill - (PTR_W+1)'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign out_valid  = (r_fill != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign fill_level = r_fill;
  assign overflow   = r_overflow;
  assign lane_err   = r_lane_err;
  assign drop_cnt   = r_drop_cnt;

endmodule
